// File: rtl/adc_trig_pkg.sv
// adc_trig_pkg
// Shared encodings for the ADC trigger/capture front end:
//   state_t    - FSM state codes, also driven out on state_o
//   MODE_*     - trigger mode selections for trig_mode_i
//   ADC_MAX    - full-scale code of the 12-bit converter, used for clamping
package adc_trig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_SW   = 2'b10;
  localparam logic [1:0] MODE_AUTO = 2'b11;

  localparam int ADC_MAX = 4095;

endpackage

// File: rtl/adc_level_detect.sv
// adc_level_detect
// Level-crossing detector with hysteresis on the registered ADC sample.
// A rising hit needs the signal to have first been at or below
// threshold-hyst; a falling hit needs it to have been at or above
// threshold+hyst. Both bands are clamped to the ADC code range.
// Ports:
//   clk_65m, rstn_i  - ADC clock, asynchronous active-high reset
//   s1, otr1         - registered sample and its out-of-range flag
//   threshold, hyst  - trigger level and hysteresis, unsigned
//   clear            - drops both arming flags (asserted on entry to ARMED)
//   rise_hit         - rising crossing on the current sample
//   fall_hit         - falling crossing on the current sample
module adc_level_detect #(
  parameter int DATA_W = 12
) (
  input  logic              clk_65m,
  input  logic              rstn_i,
  input  logic [DATA_W-1:0] s1,
  input  logic              otr1,
  input  logic [DATA_W-1:0] threshold,
  input  logic [7:0]        hyst,
  input  logic              clear,
  output logic              rise_hit,
  output logic              fall_hit
);
  import adc_trig_pkg::*;

  localparam logic [DATA_W:0] MAX_X = (DATA_W+1)'(ADC_MAX);

  logic [DATA_W:0] thr_x;
  logic [DATA_W:0] hyst_x;
  logic [DATA_W:0] s1_x;
  logic [DATA_W:0] sum_x;
  logic [DATA_W:0] lo;
  logic [DATA_W:0] hi;
  logic            below_f;
  logic            above_f;

  // One extra bit of headroom so threshold-hyst cannot wrap and
  // threshold+hyst cannot overflow before clamping.
  assign thr_x  = {1'b0, threshold};
  assign hyst_x = {{(DATA_W-7){1'b0}}, hyst};
  assign s1_x   = {1'b0, s1};
  assign sum_x  = thr_x + hyst_x;
  assign lo     = (hyst_x > thr_x) ? '0 : (thr_x - hyst_x);
  assign hi     = (sum_x > MAX_X) ? MAX_X : sum_x;

  // Out-of-range samples are untrustworthy, so they can never hit.
  assign rise_hit = below_f && !otr1 && (s1 >= threshold);
  assign fall_hit = above_f && !otr1 && (s1 <= threshold);

  // A hit consumes its arming flag so the signal must leave the
  // hysteresis band again before the next hit.
  always_ff @(posedge clk_65m or posedge rstn_i) begin
    if (rstn_i) begin
      below_f <= 1'b0;
      above_f <= 1'b0;
    end else if (clear) begin
      below_f <= 1'b0;
      above_f <= 1'b0;
    end else if (!otr1) begin
      if (rise_hit)
        below_f <= 1'b0;
      else if (s1_x <= lo)
        below_f <= 1'b1;
      if (fall_hit)
        above_f <= 1'b0;
      else if (s1_x >= hi)
        above_f <= 1'b1;
    end
  end

endmodule

// File: rtl/adc_trig_capture.sv
// adc_trig_capture
// Front end of the ADC capture FIFO in the clk_65m domain. Registers the
// ADC bus, finds a trigger (level crossing, software or free-run) and opens
// a CAPTURE_LEN-cycle write window, followed by a HOLDOFF-cycle low gap so
// the FIFO always sees a clean rising edge on wr_start_o.
// Ports:
//   clk_65m, rstn_i          - ADC clock, asynchronous active-high reset
//   adc_data_i, adc_otr_i    - raw sample and out-of-range flag
//   arm_i, abort_i           - one-cycle arm / cancel pulses
//   sw_trig_i                - one-cycle software trigger
//   trig_mode_i              - 00 rise, 01 fall, 10 software, 11 auto
//   threshold_i, hyst_i      - trigger level and hysteresis
//   data_o                   - sample delayed by two cycles
//   wr_start_o               - capture window level
//   busy_o, state_o          - FSM status
//   trig_cnt_o               - CAPTURE entries, wrapping
//   otr_cnt_o                - out-of-range samples, saturating
module adc_trig_capture #(
  parameter int DATA_W      = 12,
  parameter int CAPTURE_LEN = 1024,
  parameter int HOLDOFF     = 16,
  parameter int CNT_W       = 16
) (
  input  logic              clk_65m,
  input  logic              rstn_i,
  input  logic [DATA_W-1:0] adc_data_i,
  input  logic              adc_otr_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              sw_trig_i,
  input  logic [1:0]        trig_mode_i,
  input  logic [DATA_W-1:0] threshold_i,
  input  logic [7:0]        hyst_i,
  output logic [DATA_W-1:0] data_o,
  output logic              wr_start_o,
  output logic              busy_o,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  trig_cnt_o,
  output logic [CNT_W-1:0]  otr_cnt_o
);
  import adc_trig_pkg::*;

  // One counter times both the window and the hold-off gap.
  localparam int WIN_W = $clog2(CAPTURE_LEN) + 1;

  state_t            state;
  state_t            state_n;
  logic [DATA_W-1:0] s1;
  logic              otr1;
  logic [WIN_W-1:0]  win_cnt;
  logic              rise_hit;
  logic              fall_hit;
  logic              trig;
  logic              enter_armed;
  logic              win_done;
  logic              hold_done;

  always_ff @(posedge clk_65m or posedge rstn_i) begin
    if (rstn_i) begin
      s1     <= '0;
      otr1   <= 1'b0;
      data_o <= '0;
    end else begin
      s1     <= adc_data_i;
      otr1   <= adc_otr_i;
      data_o <= s1;
    end
  end

  adc_level_detect #(
    .DATA_W (DATA_W)
  ) u_level (
    .clk_65m   (clk_65m),
    .rstn_i    (rstn_i),
    .s1        (s1),
    .otr1      (otr1),
    .threshold (threshold_i),
    .hyst      (hyst_i),
    .clear     (enter_armed),
    .rise_hit  (rise_hit),
    .fall_hit  (fall_hit)
  );

  assign win_done  = (win_cnt == WIN_W'(CAPTURE_LEN - 1));
  assign hold_done = (win_cnt == WIN_W'(HOLDOFF - 1));

  // A crossing and a software trigger in the same cycle are one trigger.
  assign trig = sw_trig_i
             || (trig_mode_i == MODE_AUTO)
             || ((trig_mode_i == MODE_RISE) && rise_hit)
             || ((trig_mode_i == MODE_FALL) && fall_hit);

  // Abort overrides every other transition, including arm and trigger.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:    if (arm_i || (trig_mode_i == MODE_AUTO)) state_n = ST_ARMED;
      ST_ARMED:   if (trig) state_n = ST_CAPTURE;
      ST_CAPTURE: if (win_done) state_n = ST_HOLDOFF;
      ST_HOLDOFF: if (hold_done)
                    state_n = (trig_mode_i == MODE_AUTO) ? ST_ARMED : ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
    if (abort_i)
      state_n = ST_IDLE;
  end

  assign enter_armed = (state_n == ST_ARMED) && (state != ST_ARMED);

  // wr_start_o is registered from the next state so it rises on the
  // CAPTURE entry edge and drops on the same edge as an abort.
  always_ff @(posedge clk_65m or posedge rstn_i) begin
    if (rstn_i) begin
      state      <= ST_IDLE;
      wr_start_o <= 1'b0;
      win_cnt    <= '0;
      trig_cnt_o <= '0;
    end else begin
      state      <= state_n;
      wr_start_o <= (state_n == ST_CAPTURE);
      if (state_n != state)
        win_cnt <= '0;
      else if ((state == ST_CAPTURE) || (state == ST_HOLDOFF))
        win_cnt <= win_cnt + 1'b1;
      if ((state == ST_ARMED) && (state_n == ST_CAPTURE))
        trig_cnt_o <= trig_cnt_o + 1'b1;
    end
  end

  always_ff @(posedge clk_65m or posedge rstn_i) begin
    if (rstn_i)
      otr_cnt_o <= '0;
    else if (otr1 && (otr_cnt_o != '1))
      otr_cnt_o <= otr_cnt_o + 1'b1;
  end

  assign busy_o  = (state != ST_IDLE);
  assign state_o = state;

endmodule

// File: tb/tb_adc_trig_capture.sv
// tb_adc_trig_capture
// Directed bench for adc_trig_capture. A second instance with 4-bit
// counters shares every input so counter saturation and wrap can be
// reached in a few cycles.
module tb_adc_trig_capture;

  logic        clk_65m;
  logic        rstn_i;
  logic [11:0] adc_data_i;
  logic        adc_otr_i;
  logic        arm_i;
  logic        abort_i;
  logic        sw_trig_i;
  logic [1:0]  trig_mode_i;
  logic [11:0] threshold_i;
  logic [7:0]  hyst_i;

  logic [11:0] data_o;
  logic        wr_start_o;
  logic        busy_o;
  logic [1:0]  state_o;
  logic [15:0] trig_cnt_o;
  logic [15:0] otr_cnt_o;

  logic [11:0] s_data_o;
  logic        s_wr_start_o;
  logic        s_busy_o;
  logic [1:0]  s_state_o;
  logic [3:0]  s_trig_cnt_o;
  logic [3:0]  s_otr_cnt_o;

  int total;
  int bad;
  int trig_iter;
  int n;

  adc_trig_capture dut (
    .clk_65m     (clk_65m),
    .rstn_i      (rstn_i),
    .adc_data_i  (adc_data_i),
    .adc_otr_i   (adc_otr_i),
    .arm_i       (arm_i),
    .abort_i     (abort_i),
    .sw_trig_i   (sw_trig_i),
    .trig_mode_i (trig_mode_i),
    .threshold_i (threshold_i),
    .hyst_i      (hyst_i),
    .data_o      (data_o),
    .wr_start_o  (wr_start_o),
    .busy_o      (busy_o),
    .state_o     (state_o),
    .trig_cnt_o  (trig_cnt_o),
    .otr_cnt_o   (otr_cnt_o)
  );

  adc_trig_capture #(
    .CNT_W (4)
  ) dut_small (
    .clk_65m     (clk_65m),
    .rstn_i      (rstn_i),
    .adc_data_i  (adc_data_i),
    .adc_otr_i   (adc_otr_i),
    .arm_i       (arm_i),
    .abort_i     (abort_i),
    .sw_trig_i   (sw_trig_i),
    .trig_mode_i (trig_mode_i),
    .threshold_i (threshold_i),
    .hyst_i      (hyst_i),
    .data_o      (s_data_o),
    .wr_start_o  (s_wr_start_o),
    .busy_o      (s_busy_o),
    .state_o     (s_state_o),
    .trig_cnt_o  (s_trig_cnt_o),
    .otr_cnt_o   (s_otr_cnt_o)
  );

  initial clk_65m = 1'b0;
  always #5 clk_65m = ~clk_65m;

  task automatic tick();
    @(posedge clk_65m);
    #1;
  endtask

  task automatic applyStimulus(input logic [11:0] d, input logic otr);
    adc_data_i = d;
    adc_otr_i  = otr;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic armWith(input logic [11:0] d);
    arm_i = 1'b1;
    applyStimulus(d, 1'b0);
    arm_i = 1'b0;
  endtask

  task automatic abortWith(input logic [11:0] d);
    abort_i = 1'b1;
    applyStimulus(d, 1'b0);
    abort_i = 1'b0;
  endtask

  task automatic measureHigh(output int cnt);
    cnt = 0;
    while (wr_start_o === 1'b1 && cnt < 3000) begin
      cnt++;
      tick();
    end
  endtask

  task automatic measureState(input logic [1:0] st, output int cnt);
    cnt = 0;
    while (state_o === st && cnt < 200) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstn_i      = 1'b1;
    adc_data_i  = '0;
    adc_otr_i   = 1'b0;
    arm_i       = 1'b0;
    abort_i     = 1'b0;
    sw_trig_i   = 1'b0;
    trig_mode_i = 2'b00;
    threshold_i = 12'd2048;
    hyst_i      = 8'd16;
    tick();
    tick();
    checkOutput("rst_data", data_o, 0);
    checkOutput("rst_wr", wr_start_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_state", state_o, 0);
    checkOutput("rst_trig", trig_cnt_o, 0);
    checkOutput("rst_otr", otr_cnt_o, 0);
    rstn_i = 1'b0;
    tick();
    checkOutput("idle_stays", state_o, 0);

    $display("[TB] rising ramp capture");
    armWith(12'd0);
    checkOutput("armed", state_o, 1);
    checkOutput("armed_busy", busy_o, 1);
    trig_iter = -1;
    for (int i = 0; i <= 100; i++) begin
      if (trig_iter < 0) begin
        applyStimulus(12'(2000 + i), 1'b0);
        if (wr_start_o === 1'b1) trig_iter = i;
      end
    end
    checkOutput("rise_latency", trig_iter, 49);
    checkOutput("pipe_delay", data_o, 2048);
    checkOutput("trig_cnt_1", trig_cnt_o, 1);
    measureHigh(n);
    checkOutput("window_len", n, 1024);
    checkOutput("holdoff_state", state_o, 3);
    checkOutput("holdoff_busy", busy_o, 1);
    measureState(2'd3, n);
    checkOutput("holdoff_len", n, 16);
    checkOutput("after_holdoff", state_o, 0);

    $display("[TB] hysteresis with mode change while armed");
    trig_mode_i = 2'b10;
    armWith(12'd2100);
    applyStimulus(12'd2000, 1'b0);
    applyStimulus(12'd2048, 1'b0);
    applyStimulus(12'd2050, 1'b0);
    checkOutput("sw_mode_no_trig", state_o, 1);
    trig_mode_i = 2'b00;
    applyStimulus(12'd2040, 1'b0);
    applyStimulus(12'd2056, 1'b0);
    applyStimulus(12'd2040, 1'b0);
    applyStimulus(12'd2056, 1'b0);
    applyStimulus(12'd2048, 1'b0);
    applyStimulus(12'd2041, 1'b0);
    applyStimulus(12'd2048, 1'b0);
    applyStimulus(12'd2048, 1'b0);
    checkOutput("osc_no_retrig", state_o, 1);
    applyStimulus(12'd2030, 1'b0);
    applyStimulus(12'd2048, 1'b0);
    applyStimulus(12'd2048, 1'b0);
    checkOutput("dip_retrig", state_o, 2);
    checkOutput("dip_wr", wr_start_o, 1);
    checkOutput("trig_cnt_2", trig_cnt_o, 2);
    abortWith(12'd2048);
    checkOutput("abort_state", state_o, 0);
    checkOutput("abort_wr", wr_start_o, 0);

    $display("[TB] falling trigger and clamping");
    trig_mode_i = 2'b01;
    threshold_i = 12'd100;
    hyst_i      = 8'd200;
    armWith(12'd200);
    applyStimulus(12'd299, 1'b0);
    applyStimulus(12'd50, 1'b0);
    applyStimulus(12'd50, 1'b0);
    checkOutput("fall_299_no", state_o, 1);
    applyStimulus(12'd300, 1'b0);
    applyStimulus(12'd50, 1'b0);
    applyStimulus(12'd50, 1'b0);
    checkOutput("fall_300_trig", state_o, 2);
    checkOutput("trig_cnt_3", trig_cnt_o, 3);
    abortWith(12'd200);

    trig_mode_i = 2'b00;
    threshold_i = 12'd10;
    hyst_i      = 8'd50;
    armWith(12'd30);
    applyStimulus(12'd5, 1'b0);
    applyStimulus(12'd20, 1'b0);
    applyStimulus(12'd20, 1'b0);
    checkOutput("lo_clamp_no", state_o, 1);
    applyStimulus(12'd0, 1'b0);
    applyStimulus(12'd20, 1'b0);
    applyStimulus(12'd20, 1'b0);
    checkOutput("lo_clamp_trig", state_o, 2);
    checkOutput("trig_cnt_4", trig_cnt_o, 4);
    abortWith(12'd30);

    trig_mode_i = 2'b01;
    threshold_i = 12'd4090;
    hyst_i      = 8'd50;
    armWith(12'd4092);
    applyStimulus(12'd4000, 1'b0);
    applyStimulus(12'd4000, 1'b0);
    checkOutput("hi_clamp_no", state_o, 1);
    applyStimulus(12'd4095, 1'b0);
    applyStimulus(12'd4000, 1'b0);
    applyStimulus(12'd4000, 1'b0);
    checkOutput("hi_clamp_trig", state_o, 2);
    checkOutput("trig_cnt_5", trig_cnt_o, 5);
    abortWith(12'd2048);

    $display("[TB] auto mode bursts");
    trig_mode_i = 2'b11;
    applyStimulus(12'd2048, 1'b0);
    checkOutput("auto_armed", state_o, 1);
    applyStimulus(12'd2048, 1'b0);
    checkOutput("auto_capture", state_o, 2);
    checkOutput("trig_cnt_6", trig_cnt_o, 6);
    measureHigh(n);
    checkOutput("auto_window", n, 1024);
    measureState(2'd3, n);
    checkOutput("auto_holdoff", n, 16);
    checkOutput("auto_rearm", state_o, 1);
    checkOutput("auto_rearm_wr", wr_start_o, 0);
    tick();
    checkOutput("auto_burst2", wr_start_o, 1);
    checkOutput("trig_cnt_7", trig_cnt_o, 7);
    repeat (499) tick();
    checkOutput("auto_mid_wr", wr_start_o, 1);
    trig_mode_i = 2'b00;
    abortWith(12'd2048);
    checkOutput("auto_abort_wr", wr_start_o, 0);
    checkOutput("auto_abort_state", state_o, 0);

    $display("[TB] software mode and simultaneous events");
    trig_mode_i = 2'b10;
    threshold_i = 12'd2048;
    hyst_i      = 8'd16;
    armWith(12'd2048);
    applyStimulus(12'd2000, 1'b0);
    applyStimulus(12'd2100, 1'b0);
    applyStimulus(12'd2100, 1'b0);
    checkOutput("sw_ramp_no", state_o, 1);
    sw_trig_i = 1'b1;
    arm_i     = 1'b1;
    abortWith(12'd2048);
    sw_trig_i = 1'b0;
    arm_i     = 1'b0;
    checkOutput("abort_wins", state_o, 0);
    checkOutput("abort_wins_cnt", trig_cnt_o, 7);
    armWith(12'd2048);
    sw_trig_i = 1'b1;
    applyStimulus(12'd2048, 1'b0);
    sw_trig_i = 1'b0;
    checkOutput("sw_trig", state_o, 2);
    checkOutput("trig_cnt_8", trig_cnt_o, 8);
    abortWith(12'd2048);

    trig_mode_i = 2'b00;
    armWith(12'd2000);
    applyStimulus(12'd2048, 1'b0);
    sw_trig_i = 1'b1;
    applyStimulus(12'd2048, 1'b0);
    sw_trig_i = 1'b0;
    checkOutput("hit_sw_state", state_o, 2);
    checkOutput("hit_sw_once", trig_cnt_o, 9);
    abortWith(12'd2048);

    $display("[TB] out-of-range samples");
    armWith(12'd2000);
    applyStimulus(12'd2048, 1'b1);
    applyStimulus(12'd2040, 1'b0);
    applyStimulus(12'd2040, 1'b0);
    checkOutput("otr_no_trig", state_o, 1);
    checkOutput("otr_cnt_1", otr_cnt_o, 1);
    applyStimulus(12'd2050, 1'b0);
    applyStimulus(12'd2050, 1'b0);
    checkOutput("otr_flag_kept", state_o, 2);
    checkOutput("trig_cnt_10", trig_cnt_o, 10);
    abortWith(12'd2040);
    for (int i = 0; i < 20; i++) applyStimulus(12'd2040, 1'b1);
    applyStimulus(12'd2040, 1'b0);
    applyStimulus(12'd2040, 1'b0);
    checkOutput("otr_cnt_21", otr_cnt_o, 21);
    checkOutput("otr_sat_small", s_otr_cnt_o, 15);
    checkOutput("small_trig_10", s_trig_cnt_o, 10);

    trig_mode_i = 2'b10;
    for (int i = 0; i < 6; i++) begin
      armWith(12'd2048);
      sw_trig_i = 1'b1;
      applyStimulus(12'd2048, 1'b0);
      sw_trig_i = 1'b0;
      abortWith(12'd2048);
    end
    checkOutput("trig_cnt_16", trig_cnt_o, 16);
    checkOutput("small_trig_wrap", s_trig_cnt_o, 0);

    $display("[TB] reset during capture");
    trig_mode_i = 2'b11;
    applyStimulus(12'd2048, 1'b0);
    applyStimulus(12'd2048, 1'b0);
    repeat (5) tick();
    checkOutput("pre_rst_wr", wr_start_o, 1);
    rstn_i = 1'b1;
    #1;
    checkOutput("async_rst_wr", wr_start_o, 0);
    checkOutput("async_rst_state", state_o, 0);
    checkOutput("async_rst_otr", otr_cnt_o, 0);
    checkOutput("async_rst_trig", trig_cnt_o, 0);
    rstn_i = 1'b0;
    trig_mode_i = 2'b00;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
